// File: rtl/beep_sequence_writer_pkg.sv
// beep_sequence_writer_pkg.sv - shared constants, FSM encoding and pattern ROM contents
//
// Purpose: command byte width, terminator code, the 3-bit writer state encoding
//          and the stored beep patterns used by beep_pattern_rom.
// Ports:   none (package).
package beep_sequence_writer_pkg;

  localparam int BEEP_CMD_W = 8;
  localparam logic [BEEP_CMD_W-1:0] BEEP_CMD_END = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PUSH = 3'd2,
    ST_PACE = 3'd3,
    ST_DONE = 3'd4
  } beep_state_t;

  // Pattern table:
  //   0: {AA, 00}            short looping tone
  //   1: {11, 22, 33, 00}    three-note chime
  //   2: {10 .. 1F}          full-length pattern with no terminator
  //   3: {00}                empty pattern
  function automatic logic [BEEP_CMD_W-1:0] beep_pattern_byte(input int unsigned pat,
                                                              input int unsigned idx);
    logic [BEEP_CMD_W-1:0] b;
    b = BEEP_CMD_END;
    case (pat)
      0: b = (idx == 0) ? 8'hAA : BEEP_CMD_END;
      1: begin
        case (idx)
          0: b = 8'h11;
          1: b = 8'h22;
          2: b = 8'h33;
          default: b = BEEP_CMD_END;
        endcase
      end
      2: b = 8'h10 + 8'(idx);
      default: b = BEEP_CMD_END;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/beep_sequence_writer_rom.sv
// beep_sequence_writer_rom.sv - synchronous pattern ROM, one cycle read latency
//
// Purpose: PAT_NUM*PAT_LEN x 8 read-only pattern store.
// Ports:   clk, rst (sync, active high, clears q)
//          addr  [ADDR_W-1:0] read address = pattern*PAT_LEN + index
//          q     [7:0]        data for the address presented on the previous edge
module beep_pattern_rom
  import beep_sequence_writer_pkg::*;
#(
  parameter int PAT_NUM = 4,
  parameter int PAT_LEN = 16,
  parameter int ADDR_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     addr,
  output logic [BEEP_CMD_W-1:0] q
);

  localparam int unsigned LEN = PAT_LEN;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= BEEP_CMD_END;
    end else begin
      q <= beep_pattern_byte(32'(addr) / LEN, 32'(addr) % LEN);
    end
  end

endmodule

// File: rtl/beep_sequence_writer.sv
// beep_sequence_writer.sv - streams a stored beep pattern into the beep FIFO
//
// Purpose: on start_sig, reads the selected pattern byte by byte from the
//          pattern ROM and writes it into the beep FIFO, honouring full_sig.
// Ports:   clk, rst (sync, active high)
//          start_sig, pattern_sel[1:0], abort_sig   control from key/UI logic
//          full_sig                                  FIFO full flag
//          write_req, fifo_write_data[7:0]           FIFO write port
//          busy_sig, done_sig                        status
// Option:  BEEP_WRITER_REPEAT_EN - loop the pattern until abort_sig.
module beep_sequence_writer
  import beep_sequence_writer_pkg::*;
#(
  parameter int PAT_NUM     = 4,
  parameter int PAT_LEN     = 16,
  parameter int PACE_CYCLES = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_sig,
  input  logic [$clog2(PAT_NUM)-1:0] pattern_sel,
  input  logic                       abort_sig,
  input  logic                       full_sig,
  output logic                       write_req,
  output logic [BEEP_CMD_W-1:0]      fifo_write_data,
  output logic                       busy_sig,
  output logic                       done_sig
);

  localparam int SEL_W  = $clog2(PAT_NUM);
  localparam int IDX_W  = $clog2(PAT_LEN);
  localparam int ADDR_W = $clog2(PAT_NUM * PAT_LEN);
  localparam int PACE_W = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PAT_LEN - 1);
  localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'((PACE_CYCLES > 0) ? PACE_CYCLES - 1 : 0);

  beep_state_t state, state_next;
  logic [SEL_W-1:0]      sel_q, sel_next;
  logic [IDX_W-1:0]      idx, idx_next;
  logic [PACE_W-1:0]     pace_cnt, pace_next;
  logic [ADDR_W-1:0]     rom_addr;
  logic [BEEP_CMD_W-1:0] rom_q;

  // The ROM reads every cycle; idx only moves on leaving PUSH, so rom_q is
  // stable for the whole time PUSH waits on a full FIFO.
  assign rom_addr = ADDR_W'(sel_q) * ADDR_W'(PAT_LEN) + ADDR_W'(idx);

  beep_pattern_rom #(
    .PAT_NUM (PAT_NUM),
    .PAT_LEN (PAT_LEN),
    .ADDR_W  (ADDR_W)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (rom_addr),
    .q    (rom_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel_q    <= '0;
      idx      <= '0;
      pace_cnt <= '0;
    end else begin
      state    <= state_next;
      sel_q    <= sel_next;
      idx      <= idx_next;
      pace_cnt <= pace_next;
    end
  end

  always_comb begin
    state_next      = state;
    sel_next        = sel_q;
    idx_next        = idx;
    pace_next       = pace_cnt;
    write_req       = 1'b0;
    fifo_write_data = BEEP_CMD_END;
    done_sig        = 1'b0;
    busy_sig        = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        // abort wins over a simultaneous start
        if (start_sig && !abort_sig) begin
          sel_next   = pattern_sel;
          idx_next   = '0;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_next = ST_PUSH;
      end
      ST_PUSH: begin
        fifo_write_data = rom_q;
        if (rom_q == BEEP_CMD_END) begin
          state_next = ST_DONE;
        end else if (!full_sig) begin
          write_req = 1'b1;
          if (idx == IDX_LAST) begin
            state_next = ST_DONE;
          end else begin
            idx_next = idx + 1'b1;
            if (PACE_CYCLES > 0) begin
              pace_next  = '0;
              state_next = ST_PACE;
            end else begin
              state_next = ST_LOAD;
            end
          end
        end
      end
      ST_PACE: begin
        if (pace_cnt == PACE_LAST) begin
          state_next = ST_LOAD;
        end else begin
          pace_next = pace_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        done_sig = 1'b1;
        idx_next = '0;
`ifdef BEEP_WRITER_REPEAT_EN
        state_next = ST_LOAD;
`else
        state_next = ST_IDLE;
`endif
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // abort masks this cycle's write and done pulse and forces IDLE next
    if (abort_sig && state != ST_IDLE) begin
      write_req  = 1'b0;
      done_sig   = 1'b0;
      state_next = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_beep_sequence_writer.sv
// tb/tb_beep_sequence_writer.sv - directed self-checking bench for beep_sequence_writer
module tb_beep_sequence_writer;

  logic       clk;
  logic       rst;
  logic       start_a;
  logic       start_b;
  logic [1:0] pattern_sel;
  logic       abort_sig;
  logic       full_sig;
  logic       wr_a, wr_b;
  logic [7:0] data_a, data_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int checks = 0;
  int errors = 0;

  // per-cycle stimulus profiles and captured outputs, index = cycle after start
  logic       full_prof  [0:99];
  logic       abort_prof [0:99];
  logic       rst_prof   [0:99];
  logic       start_prof [0:99];
  logic [1:0] sel_prof   [0:99];
  logic       wr_log     [0:99];
  logic [7:0] dat_log    [0:99];
  logic       busy_log   [0:99];
  logic       done_log   [0:99];

  beep_sequence_writer #(.PAT_NUM(4), .PAT_LEN(16), .PACE_CYCLES(0)) dut_a (
    .clk             (clk),
    .rst             (rst),
    .start_sig       (start_a),
    .pattern_sel     (pattern_sel),
    .abort_sig       (abort_sig),
    .full_sig        (full_sig),
    .write_req       (wr_a),
    .fifo_write_data (data_a),
    .busy_sig        (busy_a),
    .done_sig        (done_a)
  );

  beep_sequence_writer #(.PAT_NUM(4), .PAT_LEN(16), .PACE_CYCLES(3)) dut_b (
    .clk             (clk),
    .rst             (rst),
    .start_sig       (start_b),
    .pattern_sel     (pattern_sel),
    .abort_sig       (abort_sig),
    .full_sig        (full_sig),
    .write_req       (wr_b),
    .fifo_write_data (data_b),
    .busy_sig        (busy_b),
    .done_sig        (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_prof(input logic [1:0] sel);
    for (int k = 0; k < 100; k++) begin
      full_prof[k]  = 1'b0;
      abort_prof[k] = 1'b0;
      rst_prof[k]   = 1'b0;
      start_prof[k] = 1'b0;
      sel_prof[k]   = sel;
      wr_log[k]     = 1'b0;
      dat_log[k]    = 8'h00;
      busy_log[k]   = 1'b0;
      done_log[k]   = 1'b0;
    end
  endtask

  // start pulse accepted on the next edge; afterwards we are in cycle 1
  task automatic launch(input int which, input logic [1:0] sel);
    pattern_sel = sel;
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic capture(input int which, input int n);
    for (int k = 1; k <= n; k++) begin
      full_sig    = full_prof[k];
      abort_sig   = abort_prof[k];
      rst         = rst_prof[k];
      pattern_sel = sel_prof[k];
      if (which == 0) start_a = start_prof[k]; else start_b = start_prof[k];
      @(negedge clk);
      wr_log[k]   = (which == 0) ? wr_a   : wr_b;
      dat_log[k]  = (which == 0) ? data_a : data_b;
      busy_log[k] = (which == 0) ? busy_a : busy_b;
      done_log[k] = (which == 0) ? done_a : done_b;
      @(posedge clk); #1;
    end
    full_sig  = 1'b0;
    abort_sig = 1'b0;
    rst       = 1'b0;
    start_a   = 1'b0;
    start_b   = 1'b0;
  endtask

  // returns a looping writer to IDLE; harmless when already idle
  task automatic recover();
    abort_sig = 1'b1;
    @(posedge clk); #1;
    abort_sig = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (wr_a !== 1'b0 || data_a !== 8'h00 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: wr=%b data=%h busy=%b done=%b required 0 00 0 0", wr_a, data_a, busy_a, done_a);
    end
    checks++;
    if (wr_b !== 1'b0 || data_b !== 8'h00 || busy_b !== 1'b0 || done_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: wr=%b data=%h busy=%b done=%b required 0 00 0 0", wr_b, data_b, busy_b, done_b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_pass();
    logic       ew;
    logic [7:0] ed;
    clear_prof(2'd1);
    launch(0, 2'd1);
    capture(0, 12);
    for (int k = 1; k <= 9; k++) begin
      ew = (k == 2 || k == 4 || k == 6);
      ed = (k == 2) ? 8'h11 : (k == 4) ? 8'h22 : 8'h33;
      checks++;
      if (wr_log[k] !== ew || (ew && dat_log[k] !== ed)) begin
        errors++;
        $display("FAIL single_write c%0d: wr=%b data=%h required wr=%b data=%h", k, wr_log[k], dat_log[k], ew, ed);
      end
      checks++;
      if (done_log[k] !== (k == 9) || busy_log[k] !== 1'b1) begin
        errors++;
        $display("FAIL single_status c%0d: done=%b busy=%b required done=%b busy=1", k, done_log[k], busy_log[k], (k == 9));
      end
    end
`ifndef BEEP_WRITER_REPEAT_EN
    for (int k = 10; k <= 12; k++) begin
      checks++;
      if (busy_log[k] !== 1'b0 || wr_log[k] !== 1'b0 || done_log[k] !== 1'b0) begin
        errors++;
        $display("FAIL single_idle c%0d: busy=%b wr=%b done=%b required 0 0 0", k, busy_log[k], wr_log[k], done_log[k]);
      end
    end
`endif
    recover();
  endtask

  task automatic test_full_stall();
    logic       ew;
    logic [7:0] ed;
    clear_prof(2'd1);
    for (int k = 3; k <= 9; k++) full_prof[k] = 1'b1;
    launch(0, 2'd1);
    capture(0, 16);
    for (int k = 1; k <= 15; k++) begin
      ew = (k == 2 || k == 10 || k == 12);
      ed = (k == 2) ? 8'h11 : (k == 10) ? 8'h22 : 8'h33;
      checks++;
      if (wr_log[k] !== ew || (ew && dat_log[k] !== ed)) begin
        errors++;
        $display("FAIL full_write c%0d: wr=%b data=%h required wr=%b data=%h", k, wr_log[k], dat_log[k], ew, ed);
      end
      checks++;
      if (done_log[k] !== (k == 15)) begin
        errors++;
        $display("FAIL full_done c%0d: done=%b required %b", k, done_log[k], (k == 15));
      end
    end
    for (int k = 4; k <= 9; k++) begin
      checks++;
      if (dat_log[k] !== 8'h22) begin
        errors++;
        $display("FAIL full_hold_data c%0d: data=%h required 22", k, dat_log[k]);
      end
    end
    recover();
  endtask

  task automatic test_pace();
    logic       ew;
    logic [7:0] ed;
    clear_prof(2'd2);
    launch(1, 2'd2);
    capture(1, 80);
    for (int k = 1; k <= 78; k++) begin
      ew = (k >= 2) && (k <= 77) && ((k - 2) % 5 == 0);
      ed = 8'h10 + 8'((k - 2) / 5);
      checks++;
      if (wr_log[k] !== ew || (ew && dat_log[k] !== ed)) begin
        errors++;
        $display("FAIL pace_write c%0d: wr=%b data=%h required wr=%b data=%h", k, wr_log[k], dat_log[k], ew, ed);
      end
      checks++;
      if (done_log[k] !== (k == 78) || busy_log[k] !== 1'b1) begin
        errors++;
        $display("FAIL pace_status c%0d: done=%b busy=%b required done=%b busy=1", k, done_log[k], busy_log[k], (k == 78));
      end
    end
`ifndef BEEP_WRITER_REPEAT_EN
    checks++;
    if (busy_log[79] !== 1'b0) begin
      errors++;
      $display("FAIL pace_idle: busy=%b required 0", busy_log[79]);
    end
`endif
    recover();
  endtask

  task automatic test_empty_pattern();
    clear_prof(2'd3);
    launch(0, 2'd3);
    capture(0, 5);
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (wr_log[k] !== 1'b0 || done_log[k] !== (k == 3) || busy_log[k] !== 1'b1) begin
        errors++;
        $display("FAIL empty c%0d: wr=%b done=%b busy=%b required 0 %b 1", k, wr_log[k], done_log[k], busy_log[k], (k == 3));
      end
    end
`ifndef BEEP_WRITER_REPEAT_EN
    checks++;
    if (busy_log[4] !== 1'b0) begin
      errors++;
      $display("FAIL empty_idle: busy=%b required 0", busy_log[4]);
    end
`endif
    recover();
  endtask

  task automatic test_abort();
    logic ew;
    clear_prof(2'd1);
    abort_prof[5] = 1'b1;
    launch(0, 2'd1);
    capture(0, 10);
    for (int k = 1; k <= 10; k++) begin
      ew = (k == 2 || k == 4);
      checks++;
      if (wr_log[k] !== ew || done_log[k] !== 1'b0 || busy_log[k] !== (k <= 5)) begin
        errors++;
        $display("FAIL abort c%0d: wr=%b done=%b busy=%b required %b 0 %b", k, wr_log[k], done_log[k], busy_log[k], ew, (k <= 5));
      end
    end
    // abort on a PUSH cycle masks that write immediately
    clear_prof(2'd1);
    abort_prof[2] = 1'b1;
    launch(0, 2'd1);
    capture(0, 4);
    checks++;
    if (wr_log[2] !== 1'b0 || busy_log[3] !== 1'b0 || busy_log[4] !== 1'b0) begin
      errors++;
      $display("FAIL abort_push: wr=%b busy3=%b busy4=%b required 0 0 0", wr_log[2], busy_log[3], busy_log[4]);
    end
    // abort together with start in IDLE: stay idle
    abort_sig   = 1'b1;
    start_a     = 1'b1;
    pattern_sel = 2'd1;
    @(posedge clk); #1;
    abort_sig = 1'b0;
    start_a   = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_idle: busy=%b required 0", busy_a);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || wr_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_idle2: busy=%b wr=%b required 0 0", busy_a, wr_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_restart_and_rst();
    clear_prof(2'd1);
    start_prof[1] = 1'b1;
    sel_prof[1]   = 2'd2;
    rst_prof[4]   = 1'b1;
    launch(0, 2'd1);
    capture(0, 8);
    checks++;
    if (wr_log[2] !== 1'b1 || dat_log[2] !== 8'h11) begin
      errors++;
      $display("FAIL restart_ignored: wr=%b data=%h required 1 11", wr_log[2], dat_log[2]);
    end
    checks++;
    if (wr_log[4] !== 1'b1 || dat_log[4] !== 8'h22) begin
      errors++;
      $display("FAIL rst_cycle_write: wr=%b data=%h required 1 22", wr_log[4], dat_log[4]);
    end
    for (int k = 5; k <= 8; k++) begin
      checks++;
      if (wr_log[k] !== 1'b0 || dat_log[k] !== 8'h00 || busy_log[k] !== 1'b0 || done_log[k] !== 1'b0) begin
        errors++;
        $display("FAIL after_rst c%0d: wr=%b data=%h busy=%b done=%b required 0 00 0 0", k, wr_log[k], dat_log[k], busy_log[k], done_log[k]);
      end
    end
    clear_prof(2'd1);
    launch(0, 2'd1);
    capture(0, 9);
    checks++;
    if (wr_log[2] !== 1'b1 || dat_log[2] !== 8'h11 || wr_log[6] !== 1'b1 || dat_log[6] !== 8'h33 || done_log[9] !== 1'b1) begin
      errors++;
      $display("FAIL new_start: wr2=%b d2=%h wr6=%b d6=%h done9=%b required 1 11 1 33 1", wr_log[2], dat_log[2], wr_log[6], dat_log[6], done_log[9]);
    end
    recover();
  endtask

  task automatic test_pattern0();
    logic ew, ed, eb;
    clear_prof(2'd0);
`ifdef BEEP_WRITER_REPEAT_EN
    abort_prof[16] = 1'b1;
`endif
    launch(0, 2'd0);
    capture(0, 17);
    for (int k = 1; k <= 17; k++) begin
`ifdef BEEP_WRITER_REPEAT_EN
      ew = (k == 2 || k == 7 || k == 12);
      ed = (k == 5 || k == 10 || k == 15);
      eb = (k <= 16);
`else
      ew = (k == 2);
      ed = (k == 5);
      eb = (k <= 5);
`endif
      checks++;
      if (wr_log[k] !== ew || (ew && dat_log[k] !== 8'hAA) || done_log[k] !== ed || busy_log[k] !== eb) begin
        errors++;
        $display("FAIL pattern0 c%0d: wr=%b data=%h done=%b busy=%b required %b AA %b %b", k, wr_log[k], dat_log[k], done_log[k], busy_log[k], ew, ed, eb);
      end
    end
    recover();
  endtask

  initial begin
    rst         = 1'b1;
    start_a     = 1'b0;
    start_b     = 1'b0;
    pattern_sel = 2'd0;
    abort_sig   = 1'b0;
    full_sig    = 1'b0;
    test_reset();
    test_single_pass();
    test_full_stall();
    test_pace();
    test_empty_pattern();
    test_abort();
    test_restart_and_rst();
    test_pattern0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
